// File: rtl/dromajo_commit_packer_if.sv
// Retire-side and commit-side signal bundle for dromajo_commit_packer.
// With COMMIT_PACKER_STALL_CNT_EN defined it also carries stall_cycles.
interface dromajo_commit_packer_if #(
   parameter int COMMIT_WIDTH = 2,
   parameter int XLEN         = 64
);
   logic                         in_valid;
   logic                         in_ready;
   logic [XLEN-1:0]              in_pc;
   logic [31:0]                  in_inst;
   logic [XLEN-1:0]              in_wdata;
   logic [XLEN-1:0]              in_mstatus;
   logic                         in_check;
   logic                         trap_valid;
   logic                         trap_ready;
   logic [XLEN-1:0]              trap_cause;
   logic [31:0]                  hartid_in;
   logic                         out_stall;
   logic [COMMIT_WIDTH-1:0]      valid;
   logic [31:0]                  hartid;
   logic [XLEN*COMMIT_WIDTH-1:0] pc;
   logic [32*COMMIT_WIDTH-1:0]   inst;
   logic [XLEN*COMMIT_WIDTH-1:0] wdata;
   logic [XLEN*COMMIT_WIDTH-1:0] mstatus;
   logic [COMMIT_WIDTH-1:0]      check;
   logic                         int_xcpt;
   logic [XLEN-1:0]              cause;
`ifdef COMMIT_PACKER_STALL_CNT_EN
   logic [31:0]                  stall_cycles;
`endif

   modport slave (
      input  in_valid, in_pc, in_inst,
      input  in_wdata, in_mstatus, in_check,
      input  trap_valid, trap_cause,
      input  hartid_in, out_stall,
      output in_ready, trap_ready,
      output valid, hartid, pc, inst,
      output wdata, mstatus, check,
      output int_xcpt, cause
`ifdef COMMIT_PACKER_STALL_CNT_EN
      , output stall_cycles
`endif
   );

   modport master (
      output in_valid, in_pc, in_inst,
      output in_wdata, in_mstatus, in_check,
      output trap_valid, trap_cause,
      output hartid_in, out_stall,
      input  in_ready, trap_ready,
      input  valid, hartid, pc, inst,
      input  wdata, mstatus, check,
      input  int_xcpt, cause
`ifdef COMMIT_PACKER_STALL_CNT_EN
      , input stall_cycles
`endif
   );
endinterface

// File: rtl/dromajo_commit_packer.sv
// Dromajo commit packer: FIFO of retirements, multi-lane bundles, ordered trap.
// Optional macro COMMIT_PACKER_STALL_CNT_EN adds the stall_cycles counter.
module dromajo_commit_packer #(
   parameter int COMMIT_WIDTH  = 2,
   parameter int XLEN          = 64,
   parameter int DEPTH         = 8,
   parameter int FLUSH_TIMEOUT = 16
) (
   input logic                   clock,
   input logic                   reset,
   dromajo_commit_packer_if.slave bus
);
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = AW + 1;
   localparam int TW    = $clog2(FLUSH_TIMEOUT) + 1;
   localparam int CWXL  = XLEN * COMMIT_WIDTH;
   localparam int CW32  = 32 * COMMIT_WIDTH;

   localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] L_CW    = CNT_W'(COMMIT_WIDTH);
   localparam logic [TW-1:0]    L_TLAST = TW'(FLUSH_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_TRAP
   } state_t;

   logic [XLEN-1:0]   r_mem_pc      [DEPTH];
   logic [31:0]       r_mem_inst    [DEPTH];
   logic [XLEN-1:0]   r_mem_wdata   [DEPTH];
   logic [XLEN-1:0]   r_mem_mstatus [DEPTH];
   logic              r_mem_check   [DEPTH];

   logic [AW-1:0]     r_wr;
   logic [AW-1:0]     r_rd;
   logic [CNT_W-1:0]  r_count;
   logic [TW-1:0]     r_timer;
   state_t            r_state;
   logic [XLEN-1:0]   r_trap_cause;

   logic [COMMIT_WIDTH-1:0] r_valid;
   logic [31:0]             r_hartid;
   logic [CWXL-1:0]         r_pc;
   logic [CW32-1:0]         r_inst;
   logic [CWXL-1:0]         r_wdata;
   logic [CWXL-1:0]         r_mstatus;
   logic [COMMIT_WIDTH-1:0] r_check;
   logic                    r_int_xcpt;
   logic [XLEN-1:0]         r_cause;

   logic                    w_in_ready;
   logic                    w_trap_ready;
   logic                    w_push;
   logic                    w_trap_acc;
   logic                    w_emit;
   logic [CNT_W-1:0]        w_n;
   logic [CNT_W-1:0]        w_count_nxt;
   logic [COMMIT_WIDTH-1:0] w_vmask;
   logic [CWXL-1:0]         w_pc;
   logic [CW32-1:0]         w_inst;
   logic [CWXL-1:0]         w_wdata;
   logic [CWXL-1:0]         w_mstatus;
   logic [COMMIT_WIDTH-1:0] w_check;

   // Handshakes are held low while reset is asserted.
   assign w_in_ready   = reset && (r_state == S_RUN) && (r_count < L_DEPTH);
   assign w_trap_ready = reset && (r_state == S_RUN);
   assign w_push       = bus.in_valid && w_in_ready;
   assign w_trap_acc   = bus.trap_valid && w_trap_ready;

   assign w_emit = !bus.out_stall && (r_count != '0) &&
                   ((r_count >= L_CW) || (r_timer == L_TLAST) ||
                    (r_state == S_DRAIN));

   assign w_n = (r_count >= L_CW) ? L_CW : r_count;

   assign w_count_nxt = r_count + CNT_W'(w_push) -
                        (w_emit ? w_n : '0);

   always_comb begin
      w_vmask   = '0;
      w_pc      = '0;
      w_inst    = '0;
      w_wdata   = '0;
      w_mstatus = '0;
      w_check   = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         if (CNT_W'(i) < w_n) begin
            w_vmask[i]               = 1'b1;
            w_pc[i*XLEN +: XLEN]      = r_mem_pc[r_rd + AW'(i)];
            w_inst[i*32 +: 32]        = r_mem_inst[r_rd + AW'(i)];
            w_wdata[i*XLEN +: XLEN]   = r_mem_wdata[r_rd + AW'(i)];
            w_mstatus[i*XLEN +: XLEN] = r_mem_mstatus[r_rd + AW'(i)];
            w_check[i]               = r_mem_check[r_rd + AW'(i)];
         end
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem_pc[r_wr]      <= bus.in_pc;
         r_mem_inst[r_wr]    <= bus.in_inst;
         r_mem_wdata[r_wr]   <= bus.in_wdata;
         r_mem_mstatus[r_wr] <= bus.in_mstatus;
         r_mem_check[r_wr]   <= bus.in_check;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr         <= '0;
         r_rd         <= '0;
         r_count      <= '0;
         r_timer      <= '0;
         r_state      <= S_RUN;
         r_trap_cause <= '0;
         r_valid      <= '0;
         r_hartid     <= '0;
         r_pc         <= '0;
         r_inst       <= '0;
         r_wdata      <= '0;
         r_mstatus    <= '0;
         r_check      <= '0;
         r_int_xcpt   <= 1'b0;
         r_cause      <= '0;
      end else begin
         r_hartid <= bus.hartid_in;
         r_count  <= w_count_nxt;
         if (w_push) begin
            r_wr <= r_wr + AW'(1);
         end
         if (w_emit) begin
            r_rd <= r_rd + w_n[AW-1:0];
         end

         r_valid   <= w_emit ? w_vmask   : '0;
         r_pc      <= w_emit ? w_pc      : '0;
         r_inst    <= w_emit ? w_inst    : '0;
         r_wdata   <= w_emit ? w_wdata   : '0;
         r_mstatus <= w_emit ? w_mstatus : '0;
         r_check   <= w_emit ? w_check   : '0;

         // Partial-bundle timer freezes under sink stall.
         if (r_count == '0) begin
            r_timer <= '0;
         end else if (bus.out_stall) begin
            r_timer <= r_timer;
         end else if (w_emit) begin
            r_timer <= '0;
         end else if ((r_state == S_RUN) && (r_count < L_CW)) begin
            r_timer <= r_timer + TW'(1);
         end

         unique case (r_state)
            S_RUN: begin
               if (w_trap_acc) begin
                  r_trap_cause <= bus.trap_cause;
                  r_state      <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Empty here means the last bundle is already on the bus.
               if (r_count == '0) begin
                  r_state    <= S_TRAP;
                  r_int_xcpt <= 1'b1;
                  r_cause    <= r_trap_cause;
               end
            end
            S_TRAP: begin
               r_state    <= S_RUN;
               r_int_xcpt <= 1'b0;
               r_cause    <= '0;
            end
            default: begin
               r_state <= S_RUN;
            end
         endcase
      end
   end

`ifdef COMMIT_PACKER_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
      end else if (bus.in_valid && !w_in_ready &&
                   (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign bus.stall_cycles = r_stall_cnt;
`endif

   assign bus.in_ready   = w_in_ready;
   assign bus.trap_ready = w_trap_ready;
   assign bus.valid      = r_valid;
   assign bus.hartid     = r_hartid;
   assign bus.pc         = r_pc;
   assign bus.inst       = r_inst;
   assign bus.wdata      = r_wdata;
   assign bus.mstatus    = r_mstatus;
   assign bus.check      = r_check;
   assign bus.int_xcpt   = r_int_xcpt;
   assign bus.cause      = r_cause;
endmodule

// File: tb/tb_dromajo_commit_packer.sv
// Scoreboard bench for dromajo_commit_packer against a queue-level model.
// Honours COMMIT_PACKER_STALL_CNT_EN for the stall counter check.
module tb_dromajo_commit_packer;
   localparam int CW    = 2;
   localparam int XLEN  = 64;
   localparam int DEPTH = 8;
   localparam int FT    = 16;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   dromajo_commit_packer_if #(.COMMIT_WIDTH(CW), .XLEN(XLEN)) bus();

   dromajo_commit_packer #(
      .COMMIT_WIDTH(CW), .XLEN(XLEN),
      .DEPTH(DEPTH), .FLUSH_TIMEOUT(FT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic [XLEN-1:0] wdata;
      logic [XLEN-1:0] mstatus;
      logic            chk;
   } ent_t;

   typedef struct {
      int                   cyc;
      bit                   trap;
      logic [CW-1:0]        vmask;
      logic [CW*XLEN-1:0]   pc;
      logic [CW*32-1:0]     inst;
      logic [CW*XLEN-1:0]   wdata;
      logic [CW*XLEN-1:0]   mstatus;
      logic [CW-1:0]        chk;
      logic [XLEN-1:0]      cause;
   } exp_t;

   ent_t mq[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   int          m_timer;
   bit          m_pend;
   bit          m_fire;
   logic [63:0] m_cause;
   int unsigned m_stall;
   logic [31:0] hart;

   always @(posedge clock) cyc++;

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, req);
      end
   endtask

   always @(negedge clock) begin : monitor
      exp_t e;
      if (reset) begin
         if (bus.valid != '0 || bus.int_xcpt) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output @cyc %0d: valid %b int_xcpt %b",
                        cyc, bus.valid, bus.int_xcpt);
            end else begin
               e = sb.pop_front();
               chk("out_cycle", cyc, e.cyc);
               chk("out_kind", bus.int_xcpt, e.trap);
               chk("valid", bus.valid, e.vmask);
               chk("hartid", bus.hartid, hart);
               if (e.trap) begin
                  chk("cause", bus.cause, e.cause);
               end else begin
                  chk("pc", bus.pc, e.pc);
                  chk("inst", bus.inst, e.inst);
                  chk("wdata", bus.wdata, e.wdata);
                  chk("mstatus", bus.mstatus, e.mstatus);
                  chk("check", bus.check, e.chk);
               end
            end
         end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_output @cyc %0d: nothing seen, expected trap=%0b valid %b",
                     cyc, e.trap, e.vmask);
         end
      end
   end

   task automatic model_cycle(input bit v, input bit tv, input bit st,
                              input bit rdy, input bit trdy,
                              input ent_t ne, input logic [63:0] tc);
      int   sz;
      int   n;
      bit   drain;
      bit   emit;
      exp_t x;
      ent_t o;
      sz    = mq.size();
      drain = m_pend && !m_fire;
      emit  = !st && sz > 0 && (sz >= CW || m_timer == FT - 1 || drain);
      if (emit) begin
         n = (sz < CW) ? sz : CW;
         x = '{cyc: cyc + 1, trap: 1'b0, vmask: '0, pc: '0, inst: '0,
               wdata: '0, mstatus: '0, chk: '0, cause: '0};
         for (int i = 0; i < n; i++) begin
            o = mq.pop_front();
            x.vmask[i]                 = 1'b1;
            x.pc[i*XLEN +: XLEN]       = o.pc;
            x.inst[i*32 +: 32]         = o.inst;
            x.wdata[i*XLEN +: XLEN]    = o.wdata;
            x.mstatus[i*XLEN +: XLEN]  = o.mstatus;
            x.chk[i]                   = o.chk;
         end
         sb.push_back(x);
      end
      if (sz == 0) m_timer = 0;
      else if (st) m_timer = m_timer;
      else if (emit) m_timer = 0;
      else if (!m_pend && sz < CW) m_timer++;
      if (m_fire) begin
         m_pend = 0;
         m_fire = 0;
      end else if (drain && sz == 0) begin
         m_fire = 1;
         x = '{cyc: cyc + 1, trap: 1'b1, vmask: '0, pc: '0, inst: '0,
               wdata: '0, mstatus: '0, chk: '0, cause: m_cause};
         sb.push_back(x);
      end
      if (v && rdy) mq.push_back(ne);
      if (tv && trdy) begin
         m_pend  = 1;
         m_cause = tc;
      end
      if (v && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
   endtask

   task automatic step(input bit v, input bit tv, input bit st,
                       input logic [63:0] pc, input logic [63:0] tc);
      ent_t ne;
      bit   rdy;
      bit   trdy;
      ne.pc      = pc;
      ne.inst    = $urandom;
      ne.wdata   = {$urandom, $urandom};
      ne.mstatus = {$urandom, $urandom};
      ne.chk     = 1'($urandom_range(0, 1));
      bus.in_valid   = v;
      bus.in_pc      = ne.pc;
      bus.in_inst    = ne.inst;
      bus.in_wdata   = ne.wdata;
      bus.in_mstatus = ne.mstatus;
      bus.in_check   = ne.chk;
      bus.trap_valid = tv;
      bus.trap_cause = tc;
      bus.out_stall  = st;
      @(negedge clock);
      rdy  = reset && !m_pend && mq.size() < DEPTH;
      trdy = reset && !m_pend;
      chk("in_ready", bus.in_ready, rdy);
      chk("trap_ready", bus.trap_ready, trdy);
      if (reset) begin
         model_cycle(v, tv, st, rdy, trdy, ne, tc);
      end else begin
         chk("rst_valid", bus.valid, 0);
         chk("rst_int_xcpt", bus.int_xcpt, 0);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(0, 0, 0, 64'd0, 64'd0);
   endtask

   task automatic do_reset(input int k);
      reset = 1'b0;
      mq.delete();
      sb.delete();
      m_timer = 0;
      m_pend  = 0;
      m_fire  = 0;
      m_stall = 0;
      #1;
      chk("rst_now_valid", bus.valid, 0);
      chk("rst_now_pc", bus.pc, 0);
      chk("rst_now_inst", bus.inst, 0);
      chk("rst_now_wdata", bus.wdata, 0);
      chk("rst_now_mstatus", bus.mstatus, 0);
      chk("rst_now_check", bus.check, 0);
      chk("rst_now_int_xcpt", bus.int_xcpt, 0);
      chk("rst_now_cause", bus.cause, 0);
      chk("rst_now_hartid", bus.hartid, 0);
      for (int i = 0; i < k; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), {$urandom, $urandom},
              {$urandom, $urandom});
      end
      reset = 1'b1;
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      hart          = $urandom;
      bus.hartid_in = hart;
      bus.in_valid  = 0;
      bus.trap_valid = 0;
      bus.out_stall = 0;
      bus.in_pc = '0; bus.in_inst = '0; bus.in_wdata = '0;
      bus.in_mstatus = '0; bus.in_check = 0; bus.trap_cause = '0;
      @(posedge clock);
      #1;
      do_reset(4);
      idle(2);

      for (int i = 0; i < 4; i++) step(1, 0, 0, 64'h8000_0000 + 64'(4 * i), 64'd0);
      idle(4);

      step(1, 0, 0, 64'h8000_0000, 64'd0);
      idle(24);

      step(1, 0, 0, 64'h8000_0100, 64'd0);
      step(1, 0, 0, 64'h8000_0104, 64'd0);
      step(1, 1, 0, 64'h8000_0108, 64'h8000_0000_0000_0007);
      idle(8);

      for (int i = 0; i < 9; i++) step(1, 0, 1, 64'h8000_0200 + 64'(4 * i), 64'd0);
`ifdef COMMIT_PACKER_STALL_CNT_EN
      chk("stall_cycles", bus.stall_cycles, m_stall);
`endif
      idle(30);

      step(1, 1, 0, 64'h8000_0300, 64'h5);
      idle(6);
      step(0, 1, 0, 64'd0, 64'hB);
      idle(6);

      for (int i = 0; i < 2000; i++) begin
         step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 3),
              1'($urandom_range(0, 99) < 20), {$urandom, $urandom},
              {$urandom, $urandom});
      end
      idle(40);
`ifdef COMMIT_PACKER_STALL_CNT_EN
      chk("stall_cycles_rand", bus.stall_cycles, m_stall);
`endif

      for (int i = 0; i < 4; i++) step(1, 0, 1, 64'h8000_0400 + 64'(4 * i), 64'd0);
      step(1, 1, 1, 64'h8000_0410, 64'h9);
      step(0, 0, 1, 64'd0, 64'd0);
      step(0, 0, 1, 64'd0, 64'd0);
      do_reset(3);
      idle(40);

      chk("scoreboard_empty", sb.size(), 0);
      chk("model_fifo_empty", mq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dromajo_commit_packer.md
Name: dromajo_commit_packer

Overview:
- DUT-side transmitter for the Dromajo co-simulation commit interface.
- Accepts retired instructions one at a time, plus trap events, from the core's retire stage through valid/ready handshakes.
- Buffers retirements in a FIFO and drives registered COMMIT_WIDTH-lane commit bundles (valid mask, hartid, pc, inst, wdata, mstatus, check) and the int_xcpt/cause trap pulse.
- The trap pulse is strictly ordered after every older commit.

Parameters:
- COMMIT_WIDTH, 2, lanes per output bundle (>=1)
- XLEN, 64, data/pc width
- DEPTH, 8, FIFO entries (power of 2, >= COMMIT_WIDTH)
- FLUSH_TIMEOUT, 16, idle cycles before a partial bundle is emitted (>=1)

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  retirement valid
- in_ready  out  1  retirement accepted
- in_pc  in  XLEN  retired pc
- in_inst  in  32  retired instruction
- in_wdata  in  XLEN  writeback data
- in_mstatus  in  XLEN  mstatus after retire
- in_check  in  1  compare-enable for this instruction
- trap_valid  in  1  interrupt/exception event
- trap_ready  out  1  trap accepted
- trap_cause  in  XLEN  trap cause
- hartid_in  in  32  hart id, quasi-static
- out_stall  in  1  inhibits bundle emission
- valid  out  COMMIT_WIDTH  lane valid mask
- hartid  out  32  registered hartid_in
- pc, wdata, mstatus  out  XLEN*COMMIT_WIDTH  each; lane i at bits [(i+1)*XLEN-1 -: XLEN]
- inst  out  32*COMMIT_WIDTH  lane i at bits [(i+1)*32-1 -: 32]
- check  out  COMMIT_WIDTH  per-lane check
- int_xcpt  out  1  one-cycle trap pulse
- cause  out  XLEN  trap cause, valid with int_xcpt

Behaviour:
- Reset (reset==0, asynchronous): all outputs 0; FIFO empty; count 0; timer 0; state RUN; no trap held.
- FIFO:
  - Pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits.
  - Push on in_valid&&in_ready.
  - in_ready = (state==RUN) && count<DEPTH. A full FIFO blocks a push even in a cycle that pops.
- Emission is evaluated each cycle when out_stall==0 and count>0. A bundle is emitted when any of the following holds:
  - count>=COMMIT_WIDTH;
  - timer==FLUSH_TIMEOUT-1;
  - state==DRAIN.
- Bundle contents:
  - n = min(count, COMMIT_WIDTH) oldest entries go to lanes 0..n-1, oldest in lane 0.
  - valid = (1<<n)-1. Unused lanes carry data 0, check 0.
  - Registered outputs: a bundle appears the cycle after its decision and persists one cycle; valid is 0 otherwise.
  - No backpressure from the sink.
- Timer:
  - Increments when state==RUN, 0<count<COMMIT_WIDTH, and no emission.
  - Clears on emission or when count==0.
  - Holds while out_stall==1.
- Trap state machine (RUN, DRAIN, TRAP):
  - trap_ready = (state==RUN).
  - RUN: on trap accept, capture trap_cause and go to DRAIN. An in_valid push in the same cycle is accepted and counts as older than the trap.
  - DRAIN: in_ready=0. Emit bundles as above until count==0 and the final bundle has been registered, then go to TRAP.
  - TRAP: drive int_xcpt=1 and cause=captured value for exactly one cycle, then return to RUN. int_xcpt is never high in a cycle with nonzero valid.
  - A trap with an empty FIFO goes RUN->DRAIN->TRAP; int_xcpt is asserted 2 cycles after acceptance.
- out_stall==1 in DRAIN delays the trap pulse until the drain completes.
- Minimum latency: a push that completes a full bundle causes valid to rise in the following cycle (1-cycle latency).
- hartid output is re-registered from hartid_in every cycle.
- Reset asserted mid-operation: buffered commits and any pending trap are discarded; outputs clear immediately.

Optional Feature:
- Macro COMMIT_PACKER_STALL_CNT_EN.
- Defined: extra output port stall_cycles (32 bits). It counts cycles with in_valid && !in_ready, saturates at 0xFFFFFFFF, and clears on reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: drive reset=0 with random inputs -> all outputs 0, in_ready=0 during reset; after release, in_ready=1 and trap_ready=1.
- Full bundles: COMMIT_WIDTH=2, push pc 0x80000000/04/08/0C on consecutive cycles -> two bundles with valid=2'b11; first has lane0 pc 0x80000000, lane1 0x80000004; second has 0x80000008/0x8000000C; each 1 cycle after its second push.
- Timeout: push one instruction at pc 0x80000000, then idle -> valid=2'b01 with pc lane0 0x80000000, appearing FLUSH_TIMEOUT=16 cycles after the push; lane1 fields 0.
- Trap ordering: push 3 instructions, trap_valid with cause 0x8000000000000007 in the same cycle as the 3rd push -> bundle 2'b11, bundle 2'b01, next cycle int_xcpt=1 with that cause for 1 cycle; in_ready and trap_ready are 0 until the return to RUN.
- Full/stall: out_stall=1, push 9 instructions -> in_ready=0 after 8 accepts (stall_cycles increments if the macro is defined); drop out_stall -> 4 consecutive bundles of 2'b11 in FIFO order.
- Reset mid-DRAIN: 5 entries buffered, trap accepted, assert reset low -> outputs 0 immediately; after release, no bundle and no int_xcpt are ever emitted.
